// File: rtl/wb_regfile.sv
// Writeback stage: selects the commit value, writes the integer register file,
// serves two bypassed read ports and counts committed writebacks.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC_added_MEM_WB,
  input  logic [DATA_W-1:0] alu_result_MEM_WB,
  input  logic [DATA_W-1:0] Dcache_out_MEM_WB,
  input  logic [AW-1:0]     write_addr,
  input  logic              RF_write,
  input  logic              lw_select,
  input  logic              jal_sel,
  input  logic              Istall,
  input  logic              Dstall,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_fwd_en,
  output logic [CNT_W-1:0]  wb_count
);

  logic              stall;
  logic              wr_valid;
  logic              we;
  logic [DATA_W-1:0] rf [NREG];

  assign stall    = Istall | Dstall;
  assign wr_valid = RF_write & (write_addr != '0);
  assign we       = wr_valid & ~stall;
  // Forwarding stays valid through a stall because MEM/WB holds its value.
  assign wb_fwd_en = wr_valid;

  always_comb begin
    wb_data = alu_result_MEM_WB;
    if (jal_sel)
      wb_data = PC_added_MEM_WB;
    else if (lw_select)
      wb_data = Dcache_out_MEM_WB;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (we) begin
      rf[write_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      wb_count <= '0;
    else if (RF_write && !stall)
      wb_count <= wb_count + CNT_W'(1);
  end

  always_comb begin
    rs1_data = rf[rs1_addr];
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (RF_write && (rs1_addr == write_addr))
      rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = rf[rs2_addr];
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (RF_write && (rs2_addr == write_addr))
      rs2_data = wb_data;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: table of per-cycle vectors plus hand-written
// reset, stall-reset and counter-wrap sequences.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_added_MEM_WB, alu_result_MEM_WB, Dcache_out_MEM_WB;
  logic [4:0]  write_addr, rs1_addr, rs2_addr;
  logic        RF_write, lw_select, jal_sel, Istall, Dstall;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_fwd_en;
  logic [63:0] wb_count;
  logic [31:0] w_rs1_data, w_rs2_data, w_wb_data;
  logic        w_wb_fwd_en;
  logic [3:0]  w_wb_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .PC_added_MEM_WB(PC_added_MEM_WB), .alu_result_MEM_WB(alu_result_MEM_WB),
    .Dcache_out_MEM_WB(Dcache_out_MEM_WB), .write_addr(write_addr),
    .RF_write(RF_write), .lw_select(lw_select), .jal_sel(jal_sel),
    .Istall(Istall), .Dstall(Dstall), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
    .wb_fwd_en(wb_fwd_en), .wb_count(wb_count)
  );

  wb_regfile #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst),
    .PC_added_MEM_WB(PC_added_MEM_WB), .alu_result_MEM_WB(alu_result_MEM_WB),
    .Dcache_out_MEM_WB(Dcache_out_MEM_WB), .write_addr(write_addr),
    .RF_write(RF_write), .lw_select(lw_select), .jal_sel(jal_sel),
    .Istall(Istall), .Dstall(Dstall), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(w_rs1_data), .rs2_data(w_rs2_data), .wb_data(w_wb_data),
    .wb_fwd_en(w_wb_fwd_en), .wb_count(w_wb_count)
  );

  typedef struct {
    string       nm;
    logic        rfw, jal, lw, is, ds;
    logic [4:0]  wa, r1, r2;
    logic [31:0] alu, ld, pc;
    logic [31:0] e_wb;
    logic        e_fwd;
    logic [31:0] e_r1, e_r2;
    logic [63:0] e_cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later, before
  // the next rising edge commits.
  task automatic drive(input logic rs, input logic rfw, input logic jal, input logic lw,
                       input logic is, input logic ds, input logic [4:0] wa,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc);
    @(negedge clk);
    rst = rs; RF_write = rfw; jal_sel = jal; lw_select = lw; Istall = is; Dstall = ds;
    write_addr = wa; rs1_addr = r1; rs2_addr = r2;
    alu_result_MEM_WB = alu; Dcache_out_MEM_WB = ld; PC_added_MEM_WB = pc;
    #1;
  endtask

  initial begin
    tbl[0]  = '{"t2_alu",   1,0,0,0,0, 3, 3,4, 32'h11,32'h22,32'h33, 32'h11,1,32'h11,0,0};
    tbl[1]  = '{"t2_ld",    1,0,1,0,0, 3, 3,4, 32'h11,32'h22,32'h33, 32'h22,1,32'h22,0,1};
    tbl[2]  = '{"t2_pc",    1,1,0,0,0, 3, 3,4, 32'h11,32'h22,32'h33, 32'h33,1,32'h33,0,2};
    tbl[3]  = '{"t2_both",  1,1,1,0,0, 3, 3,4, 32'h11,32'h22,32'h33, 32'h33,1,32'h33,0,3};
    tbl[4]  = '{"t2_rd",    0,0,0,0,0, 3, 3,0, 32'h11,32'h22,32'h33, 32'h11,0,32'h33,0,4};
    tbl[5]  = '{"t3_x0",    1,0,0,0,0, 0, 0,3, 32'hFFFFFFFF,0,0, 32'hFFFFFFFF,0,0,32'h33,4};
    tbl[6]  = '{"t3_after", 0,0,0,0,0, 0, 0,0, 0,0,0, 0,0,0,0,5};
    tbl[7]  = '{"t4_a",     1,0,0,0,0, 7, 7,7, 32'hA,0,0, 32'hA,1,32'hA,32'hA,5};
    tbl[8]  = '{"t4_b",     1,0,0,0,0, 7, 7,7, 32'hB,0,0, 32'hB,1,32'hB,32'hB,6};
    tbl[9]  = '{"t4_hold",  0,0,0,0,0, 7, 7,7, 32'hC,0,0, 32'hC,0,32'hB,32'hB,7};
    tbl[10] = '{"t5_s1",    1,0,0,0,1, 9, 9,7, 32'h5,0,0, 32'h5,1,32'h5,32'hB,7};
    tbl[11] = '{"t5_s2",    1,0,0,0,1, 9, 9,7, 32'h5,0,0, 32'h5,1,32'h5,32'hB,7};
    tbl[12] = '{"t5_s3",    1,0,0,0,1, 9, 9,7, 32'h5,0,0, 32'h5,1,32'h5,32'hB,7};
    tbl[13] = '{"t5_rel",   1,0,0,0,0, 9, 9,7, 32'h5,0,0, 32'h5,1,32'h5,32'hB,7};
    tbl[14] = '{"t5_rd",    0,0,0,0,0, 9, 9,9, 0,0,0, 0,0,32'h5,32'h5,8};
    tbl[15] = '{"t5_istl",  1,0,0,1,0, 10, 10,9, 32'h77,0,0, 32'h77,1,32'h77,32'h5,8};
    tbl[16] = '{"t5_isrd",  0,0,0,0,0, 10, 10,0, 0,0,0, 0,0,0,0,8};

    // Reset held two cycles with a pending write to x5.
    drive(0, 1,0,0,0,0, 5, 5,5, 32'h55,0,0);
    drive(0, 1,0,0,0,0, 5, 5,5, 32'h55,0,0);
    chk("t1_cnt_in_rst", wb_count, 64'd0);
    chk("t1_byp_in_rst", {32'd0, rs1_data}, 64'h55);
    drive(1, 0,0,0,0,0, 5, 5,6, 32'h55,0,0);
    chk("t1_rs1", {32'd0, rs1_data}, 64'd0);
    chk("t1_rs2", {32'd0, rs2_data}, 64'd0);
    chk("t1_cnt", wb_count, 64'd0);
    chk("t1_cnt_w", {60'd0, w_wb_count}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      drive(1, tbl[i].rfw, tbl[i].jal, tbl[i].lw, tbl[i].is, tbl[i].ds, tbl[i].wa,
            tbl[i].r1, tbl[i].r2, tbl[i].alu, tbl[i].ld, tbl[i].pc);
      chk({tbl[i].nm, "_wb"},  {32'd0, wb_data},  {32'd0, tbl[i].e_wb});
      chk({tbl[i].nm, "_fwd"}, {63'd0, wb_fwd_en}, {63'd0, tbl[i].e_fwd});
      chk({tbl[i].nm, "_rs1"}, {32'd0, rs1_data}, {32'd0, tbl[i].e_r1});
      chk({tbl[i].nm, "_rs2"}, {32'd0, rs2_data}, {32'd0, tbl[i].e_r2});
      chk({tbl[i].nm, "_cnt"}, wb_count, tbl[i].e_cnt);
    end

    // Reset beats a same-cycle commit.
    drive(0, 1,0,0,0,0, 12, 12,0, 32'h12,0,0);
    drive(1, 0,0,0,0,0, 12, 12,0, 0,0,0);
    chk("rw_rs1", {32'd0, rs1_data}, 64'd0);
    chk("rw_cnt", wb_count, 64'd0);

    // Reset during a stall drops the held write.
    drive(1, 1,0,0,0,1, 11, 11,0, 32'h99,0,0);
    chk("rs_byp", {32'd0, rs1_data}, 64'h99);
    drive(0, 1,0,0,0,1, 11, 11,0, 32'h99,0,0);
    drive(1, 0,0,0,0,0, 11, 11,0, 0,0,0);
    chk("rs_rs1", {32'd0, rs1_data}, 64'd0);
    chk("rs_cnt", wb_count, 64'd0);

    // 16 commits on the 4-bit counter: 0xF then wrap to 0.
    for (int i = 0; i < 16; i++) begin
      drive(1, 1,0,0,0,0, 1, 0,0, 32'(i + 100),0,0);
      if (i == 15) chk("wr_cnt_w_f", {60'd0, w_wb_count}, 64'hF);
    end
    drive(1, 0,0,0,0,0, 1, 1,0, 0,0,0);
    chk("wr_cnt_w_0", {60'd0, w_wb_count}, 64'd0);
    chk("wr_cnt_64", wb_count, 64'd16);
    chk("wr_rf1", {32'd0, rs1_data}, 64'd115);

    // Reset asserted on the 8th commit.
    drive(0, 0,0,0,0,0, 0, 0,0, 0,0,0);
    for (int i = 0; i < 7; i++)
      drive(1, 1,0,0,0,0, 2, 0,0, 32'h1,0,0);
    drive(0, 1,0,0,0,0, 2, 0,0, 32'h1,0,0);
    chk("r8_cnt_w_7", {60'd0, w_wb_count}, 64'd7);
    drive(1, 0,0,0,0,0, 0, 2,0, 0,0,0);
    chk("r8_cnt_w", {60'd0, w_wb_count}, 64'd0);
    chk("r8_cnt", wb_count, 64'd0);
    chk("r8_rf2", {32'd0, rs1_data}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
